load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 33 +++
 rtl/lsu_if.sv | 36 +++
 rtl/lsu_lane_align.sv | 55 +++++
 rtl/load_store_unit.sv | 135 +++++++++++++
 tb/tb_load_store_unit.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared widths, access-size encodings, FSM state type and the
// alignment rule for the load/store unit.
package lsu_pkg;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned HALF_W = 16;
    localparam int unsigned BYTE_W = 8;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RMW_RD = 2'd1,
        RMW_WR = 2'd2
    } lsu_state_e;

    // True when the access cannot be served: unaligned halfword/word or the illegal size.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = offset[0];
            SZ_WORD: bad = (offset != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_if.sv
// lsu_if: core request/response channel plus data-memory port of the LSU.
//   slave  : LSU side (takes requests, drives responses and memory strobes)
//   master : core/memory side (drives requests and mem_rdata)
interface lsu_if;

    logic                         req_valid;
    logic                         req_ready;
    logic                         req_write;
    logic [1:0]                   req_size;
    logic                         req_unsigned;
    logic [lsu_pkg::ADDR_W-1:0]   req_addr;
    logic [lsu_pkg::DATA_W-1:0]   req_wdata;

    logic                         rsp_valid;
    logic [lsu_pkg::DATA_W-1:0]   rsp_rdata;
    logic                         rsp_err;

    logic [lsu_pkg::ADDR_W-1:0]   mem_addr;
    logic [lsu_pkg::DATA_W-1:0]   mem_wdata;
    logic [lsu_pkg::DATA_W-1:0]   mem_rdata;
    logic                         mem_read;
    logic                         mem_write;

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output mem_addr, mem_wdata, mem_read, mem_write
    );

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  mem_addr, mem_wdata, mem_read, mem_write
    );

endinterface

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: combinational little-endian lane handling.
//   ld_*  : pick byte/halfword lane out of a memory word and extend it -> ld_data_c
//   st_*  : replace the target lane of a memory word with store data -> st_word_c
// Build option: LSU_SIGN_EXT_EN enables sign extension when ld_unsigned=0;
// without it every load zero-extends and ld_unsigned is ignored.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [DATA_W-1:0] ld_word,
    input  logic [1:0]        ld_offset,
    input  logic [1:0]        ld_size,
    input  logic              ld_unsigned,
    output logic [DATA_W-1:0] ld_data_c,

    input  logic [DATA_W-1:0] st_word,
    input  logic [1:0]        st_offset,
    input  logic [1:0]        st_size,
    input  logic [HALF_W-1:0] st_data,
    output logic [DATA_W-1:0] st_word_c
);

    logic              sext_c;
    logic [BYTE_W-1:0] ld_byte_c;
    logic [HALF_W-1:0] ld_half_c;

`ifdef LSU_SIGN_EXT_EN
    assign sext_c = ~ld_unsigned;
`else
    logic unused_unsigned;
    assign unused_unsigned = ld_unsigned;
    assign sext_c          = 1'b0;
`endif

    // Load lane extract and extend.
    always_comb begin
        ld_byte_c = ld_word[{ld_offset, 3'b000} +: BYTE_W];
        ld_half_c = ld_word[{ld_offset[1], 4'b0000} +: HALF_W];
        case (ld_size)
            SZ_BYTE: ld_data_c = {{(DATA_W-BYTE_W){sext_c & ld_byte_c[BYTE_W-1]}}, ld_byte_c};
            SZ_HALF: ld_data_c = {{(DATA_W-HALF_W){sext_c & ld_half_c[HALF_W-1]}}, ld_half_c};
            default: ld_data_c = ld_word;
        endcase
    end

    // Store lane merge; only byte/halfword reach the read-modify-write path.
    always_comb begin
        st_word_c = st_word;
        case (st_size)
            SZ_BYTE: st_word_c[{st_offset, 3'b000} +: BYTE_W]    = st_data[BYTE_W-1:0];
            SZ_HALF: st_word_c[{st_offset[1], 4'b0000} +: HALF_W] = st_data;
            default: st_word_c = st_word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: byte/halfword/word load-store unit in front of a word-wide
// data memory. Loads and word stores complete in one cycle; byte/halfword
// stores run a read-modify-write (IDLE -> RMW_RD -> RMW_WR).
//   clk, reset : clock, synchronous active-high reset
//   bus        : lsu_if.slave (req_*, rsp_*, mem_*)
// Build option: LSU_SIGN_EXT_EN (see lsu_lane_align) selects sign extension.
module load_store_unit
    import lsu_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    lsu_if.slave  bus
);

    lsu_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        size_q, size_d;
    logic [HALF_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] word_q, word_d;

    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

    logic              accept_c;
    logic              misaligned_c;
    logic              mem_read_c, mem_write_c;
    logic [ADDR_W-1:0] mem_addr_c;
    logic [DATA_W-1:0] mem_wdata_c;
    logic [DATA_W-1:0] ld_data_c, st_word_c;

    lsu_lane_align u_align (
        .ld_word     (bus.mem_rdata),
        .ld_offset   (bus.req_addr[1:0]),
        .ld_size     (bus.req_size),
        .ld_unsigned (bus.req_unsigned),
        .ld_data_c   (ld_data_c),
        .st_word     (word_q),
        .st_offset   (addr_q[1:0]),
        .st_size     (size_q),
        .st_data     (data_q),
        .st_word_c   (st_word_c)
    );

    assign bus.req_ready = (state_q == IDLE) && !reset;
    assign accept_c      = bus.req_valid && bus.req_ready;
    assign misaligned_c  = is_misaligned(bus.req_size, bus.req_addr[1:0]);

    // Strobes are forced low during reset so an abandoned RMW never writes.
    assign bus.mem_read  = mem_read_c && !reset;
    assign bus.mem_write = mem_write_c && !reset;
    assign bus.mem_addr  = mem_addr_c;
    assign bus.mem_wdata = mem_wdata_c;

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;

    // Next-state, datapath and strobe decode.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        size_d      = size_q;
        data_d      = data_q;
        word_d      = word_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
        mem_read_c  = 1'b0;
        mem_write_c = 1'b0;
        mem_addr_c  = {bus.req_addr[ADDR_W-1:2], 2'b00};
        mem_wdata_c = bus.req_wdata;

        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    if (misaligned_c) begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else if (!bus.req_write) begin
                        mem_read_c  = 1'b1;
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = ld_data_c;
                    end else if (bus.req_size == SZ_WORD) begin
                        mem_write_c = 1'b1;
                        rsp_valid_d = 1'b1;
                    end else begin
                        addr_d  = bus.req_addr;
                        size_d  = bus.req_size;
                        data_d  = bus.req_wdata[HALF_W-1:0];
                        state_d = RMW_RD;
                    end
                end
            end
            RMW_RD: begin
                mem_addr_c = {addr_q[ADDR_W-1:2], 2'b00};
                mem_read_c = 1'b1;
                word_d     = bus.mem_rdata;
                state_d    = RMW_WR;
            end
            RMW_WR: begin
                mem_addr_c  = {addr_q[ADDR_W-1:2], 2'b00};
                mem_wdata_c = st_word_c;
                mem_write_c = 1'b1;
                rsp_valid_d = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered datapath.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            size_q      <= SZ_BYTE;
            data_q      <= '0;
            word_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            size_q      <= size_d;
            data_q      <= data_d;
            word_q      <= word_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed + random check of load_store_unit against a
// byte-addressed reference memory model.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    lsu_if bus ();

    load_store_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Word-wide data memory seen by the DUT.
    logic [31:0] dmem [64];
    logic        bd_we   = 1'b0;
    logic [5:0]  bd_idx  = '0;
    logic [31:0] bd_data = '0;

    assign bus.mem_rdata = dmem[bus.mem_addr[7:2]];

    always @(posedge clk) begin
        if (bus.mem_write) dmem[bus.mem_addr[7:2]] <= bus.mem_wdata;
        else if (bd_we)    dmem[bd_idx] <= bd_data;
    end

    // Reference model: plain byte array.
    logic [7:0] ref_mem [256];

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        chk("strobe_exclusive", 32'(bus.mem_read && bus.mem_write), 32'd0);
        if (reset) chk("strobe_in_reset", 32'({bus.mem_read, bus.mem_write}), 32'd0);
    end

    function automatic bit tb_misaligned(input logic [1:0] sz, input logic [7:0] a);
        return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] sz, input bit uns, input logic [7:0] a);
        int n;
        logic [31:0] v;
        n = 1 << sz;
        v = '0;
        for (int i = 0; i < n; i++)
            v = v | (32'(ref_mem[(int'(a) + i) % 256]) << (8 * i));
`ifdef LSU_SIGN_EXT_EN
        if (!uns && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
`else
        if (uns) v = v;
`endif
        return v;
    endfunction

    task automatic model_store(input logic [1:0] sz, input logic [7:0] a, input logic [31:0] wd);
        int n;
        n = 1 << sz;
        for (int i = 0; i < n; i++) ref_mem[(int'(a) + i) % 256] = wd[8*i +: 8];
    endtask

    function automatic logic [31:0] model_word(input int a);
        int b;
        b = a & 252;
        return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
    endfunction

    // One request from IDLE to its response; entered and left at posedge+1.
    task automatic run_txn(input bit w, input logic [1:0] sz, input bit uns,
                           input logic [7:0] a, input logic [31:0] wd);
        bit          mis;
        bit          rmw;
        logic [31:0] exp_rd;
        logic [7:0]  wa;
        mis = tb_misaligned(sz, a);
        rmw = w && !mis && (sz != 2'd2);
        wa  = a & 8'hFC;
        exp_rd = (!mis && !w) ? model_load(sz, uns, a) : 32'd0;

        bus.req_valid    = 1'b1;
        bus.req_write    = w;
        bus.req_size     = sz;
        bus.req_unsigned = uns;
        bus.req_addr     = a;
        bus.req_wdata    = wd;
        @(negedge clk);
        chk("acc_ready", 32'(bus.req_ready), 32'd1);
        chk("acc_rsp_idle", 32'(bus.rsp_valid), 32'd0);
        if (mis || rmw) begin
            chk("acc_no_strobe", 32'({bus.mem_read, bus.mem_write}), 32'd0);
        end else if (!w) begin
            chk("ld_read", 32'({bus.mem_read, bus.mem_write}), 32'd2);
            chk("ld_addr", 32'(bus.mem_addr), 32'(wa));
        end else begin
            chk("stw_write", 32'({bus.mem_read, bus.mem_write}), 32'd1);
            chk("stw_addr", 32'(bus.mem_addr), 32'(wa));
            chk("stw_wdata", bus.mem_wdata, wd);
        end
        if (w && !mis) model_store(sz, a, wd);
        @(posedge clk);
        #1;
        if (rmw) begin
            // Unrelated request held while busy must be ignored.
            bus.req_write = 1'b1;
            bus.req_size  = 2'd2;
            bus.req_addr  = (a ^ 8'h80) & 8'hFC;
            bus.req_wdata = $urandom;
            @(negedge clk);
            chk("rmw_rd_ready", 32'(bus.req_ready), 32'd0);
            chk("rmw_rd_strobe", 32'({bus.mem_read, bus.mem_write}), 32'd2);
            chk("rmw_rd_addr", 32'(bus.mem_addr), 32'(wa));
            chk("rmw_rd_rsp", 32'(bus.rsp_valid), 32'd0);
            @(negedge clk);
            chk("rmw_wr_ready", 32'(bus.req_ready), 32'd0);
            chk("rmw_wr_strobe", 32'({bus.mem_read, bus.mem_write}), 32'd1);
            chk("rmw_wr_addr", 32'(bus.mem_addr), 32'(wa));
            chk("rmw_wr_wdata", bus.mem_wdata, model_word(int'(a)));
            chk("rmw_wr_rsp", 32'(bus.rsp_valid), 32'd0);
            bus.req_valid = 1'b0;
            @(posedge clk);
            #1;
        end else begin
            bus.req_valid = 1'b0;
        end
        @(negedge clk);
        chk("rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("rsp_err", 32'(bus.rsp_err), 32'(mis));
        chk("rsp_rdata", bus.rsp_rdata, exp_rd);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;
        logic [1:0]  sz;
        logic [7:0]  a;
        bus.req_valid    = 1'b0;
        bus.req_write    = 1'b0;
        bus.req_size     = 2'd0;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = '0;
        bus.req_wdata    = '0;

        // Preload memory and model while reset is held.
        for (int i = 0; i < 64; i++) begin
            w = $urandom;
            if (i == 1) w = 32'h8899AABB;
            if (i == 2) w = 32'h11223344;
            if (i == 3) w = 32'h12348001;
            bd_we   = 1'b1;
            bd_idx  = 6'(i);
            bd_data = w;
            for (int j = 0; j < 4; j++) ref_mem[4*i+j] = w[8*j +: 8];
            @(posedge clk);
            #1;
        end
        bd_we = 1'b0;

        // Reset state, with a request pending.
        bus.req_valid = 1'b1;
        bus.req_addr  = 8'h04;
        bus.req_size  = 2'd2;
        @(negedge clk);
        chk("rst_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        #1;

        // Byte load signed/unsigned from word 0x8899AABB at 0x05.
        run_txn(1'b0, SZ_BYTE, 1'b0, 8'h05, 32'd0);
        run_txn(1'b0, SZ_BYTE, 1'b1, 8'h05, 32'd0);
        // Halfword RMW store 0xBEEF at 0x0A into 0x11223344.
        run_txn(1'b1, SZ_HALF, 1'b0, 8'h0A, 32'h0000BEEF);
        run_txn(1'b0, SZ_WORD, 1'b0, 8'h08, 32'd0);
        // Misaligned word store, then confirm word unchanged.
        run_txn(1'b1, SZ_WORD, 1'b0, 8'h06, 32'hDEADBEEF);
        run_txn(1'b0, SZ_WORD, 1'b0, 8'h04, 32'd0);
        // Halfword load 0x8001 signed access.
        run_txn(1'b0, SZ_HALF, 1'b0, 8'h0C, 32'd0);
        // Illegal size.
        run_txn(1'b0, SZ_ILL, 1'b0, 8'h10, 32'd0);

        // Reset during RMW_WR of a byte store to 0x10 abandons it.
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_size  = SZ_BYTE;
        bus.req_addr  = 8'h10;
        bus.req_wdata = 32'(~ref_mem[16]);
        @(negedge clk);
        chk("abn_acc_strobe", 32'({bus.mem_read, bus.mem_write}), 32'd0);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("abn_rd_strobe", 32'({bus.mem_read, bus.mem_write}), 32'd2);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        chk("abn_wr_strobe", 32'({bus.mem_read, bus.mem_write}), 32'd0);
        chk("abn_ready_rst", 32'(bus.req_ready), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("abn_ready", 32'(bus.req_ready), 32'd1);
        chk("abn_no_rsp", 32'(bus.rsp_valid), 32'd0);
        chk("abn_mem", dmem[4], model_word(16));
        @(posedge clk);
        #1;
        run_txn(1'b0, SZ_WORD, 1'b0, 8'h10, 32'd0);

        // Back-to-back word store then load of 0x20.
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_size  = SZ_WORD;
        bus.req_addr  = 8'h20;
        bus.req_wdata = 32'hCAFEF00D;
        @(negedge clk);
        chk("b2b_st_strobe", 32'({bus.mem_read, bus.mem_write}), 32'd1);
        chk("b2b_st_wdata", bus.mem_wdata, 32'hCAFEF00D);
        model_store(SZ_WORD, 8'h20, 32'hCAFEF00D);
        @(posedge clk);
        #1;
        bus.req_write = 1'b0;
        @(negedge clk);
        chk("b2b_st_rsp", 32'(bus.rsp_valid), 32'd1);
        chk("b2b_st_rdata", bus.rsp_rdata, 32'd0);
        chk("b2b_ld_ready", 32'(bus.req_ready), 32'd1);
        chk("b2b_ld_strobe", 32'({bus.mem_read, bus.mem_write}), 32'd2);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("b2b_ld_rsp", 32'(bus.rsp_valid), 32'd1);
        chk("b2b_ld_rdata", bus.rsp_rdata, model_load(SZ_WORD, 1'b0, 8'h20));
        @(posedge clk);
        #1;

        // Random traffic.
        for (int k = 0; k < 120; k++) begin
            sz = 2'($urandom_range(0, 3));
            a  = 8'($urandom);
            if ($urandom_range(0, 3) != 0 && sz != 2'd3) a = a & ~8'((1 << sz) - 1);
            run_txn(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
        end

        // Whole-memory consistency with the model.
        @(negedge clk);
        for (int i = 0; i < 64; i++) chk("mem_sweep", dmem[i], model_word(4 * i));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
